// File: rtl/md_pkg.sv
// md_pkg: shared op codes, widths and request payload for the multiply/divide unit.
// The decoder and hazard unit import the same codes.
package md_pkg;

  localparam int unsigned MD_OP_W  = 4;
  localparam int unsigned MD_CNT_W = 5;
  localparam int unsigned MD_DW    = 32;

  localparam logic [MD_OP_W-1:0] OP_MULT  = MD_OP_W'(0);
  localparam logic [MD_OP_W-1:0] OP_MULTU = MD_OP_W'(1);
  localparam logic [MD_OP_W-1:0] OP_DIV   = MD_OP_W'(2);
  localparam logic [MD_OP_W-1:0] OP_DIVU  = MD_OP_W'(3);
  localparam logic [MD_OP_W-1:0] OP_MTHI  = MD_OP_W'(4);
  localparam logic [MD_OP_W-1:0] OP_MTLO  = MD_OP_W'(5);
  localparam logic [MD_OP_W-1:0] OP_MADD  = MD_OP_W'(6);
  localparam logic [MD_OP_W-1:0] OP_MADDU = MD_OP_W'(7);
  localparam logic [MD_OP_W-1:0] OP_MSUB  = MD_OP_W'(8);
  localparam logic [MD_OP_W-1:0] OP_MSUBU = MD_OP_W'(9);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Operation latched at accept; the result is computed from this, not the live operands.
  typedef struct packed {
    logic [MD_OP_W-1:0] op;
    logic [MD_DW-1:0]   a;
    logic [MD_DW-1:0]   b;
  } md_req_t;

  // Multi-cycle ops that use the multiply latency (MADD* only when the accumulator is built).
  function automatic logic md_is_mul(input logic [MD_OP_W-1:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MD_UNIT_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational {hi,lo} next value from the latched request and current hi/lo.
// Divide by zero holds hi/lo. MADD/MSUB paths exist only with MD_UNIT_MADD_EN.
module md_calc
  import md_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [MD_DW-1:0]   a,
  input  logic [MD_DW-1:0]   b,
  input  logic [MD_DW-1:0]   hi,
  input  logic [MD_DW-1:0]   lo,
  output logic [2*MD_DW-1:0] nxt_c
);

  logic [2*MD_DW-1:0]       a_sx;
  logic [2*MD_DW-1:0]       b_sx;
  logic [2*MD_DW-1:0]       prod_s;
  logic [2*MD_DW-1:0]       prod_u;
  logic                     div_zero;
  logic                     div_ovf;
  logic [MD_DW-1:0]         udiv_b;
  logic [MD_DW-1:0]         sdiv_b;
  logic [MD_DW-1:0]         q_u;
  logic [MD_DW-1:0]         r_u;
  logic signed [MD_DW-1:0]  q_s;
  logic signed [MD_DW-1:0]  r_s;

  // Products and quotients for every op; the op select picks one.
  always_comb begin
    a_sx   = {{MD_DW{a[MD_DW-1]}}, a};
    b_sx   = {{MD_DW{b[MD_DW-1]}}, b};
    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    prod_s = a_sx * b_sx;
    prod_u = {{MD_DW{1'b0}}, a} * {{MD_DW{1'b0}}, b};

    div_zero = (b == '0);
    div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    // Divisors forced to 1 where the true division is undefined; those results are muxed away.
    udiv_b   = div_zero ? MD_DW'(1) : b;
    sdiv_b   = (div_zero || div_ovf) ? MD_DW'(1) : b;

    q_u = a / udiv_b;
    r_u = a % udiv_b;
    if (div_ovf) begin
      q_s = 32'sh8000_0000;
      r_s = '0;
    end else begin
      q_s = $signed(a) / $signed(sdiv_b);
      r_s = $signed(a) % $signed(sdiv_b);
    end
  end

  // Result select; unknown or non-computing ops keep {hi,lo}.
  always_comb begin
    nxt_c = {hi, lo};
    case (op)
      OP_MULT:  nxt_c = prod_s;
      OP_MULTU: nxt_c = prod_u;
      OP_DIV:   if (!div_zero) nxt_c = {MD_DW'(r_s), MD_DW'(q_s)};
      OP_DIVU:  if (!div_zero) nxt_c = {r_u, q_u};
`ifdef MD_UNIT_MADD_EN
      OP_MADD:  nxt_c = {hi, lo} + prod_s;
      OP_MADDU: nxt_c = {hi, lo} + prod_u;
      OP_MSUB:  nxt_c = {hi, lo} - prod_s;
      OP_MSUBU: nxt_c = {hi, lo} - prod_u;
`endif
      default:  nxt_c = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MADD/MADDU/MSUB/MSUBU enabled by defining MD_UNIT_MADD_EN.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [MD_DW-1:0]   a,
  input  logic [MD_DW-1:0]   b,
  output logic               busy,
  output logic [MD_DW-1:0]   hi,
  output logic [MD_DW-1:0]   lo
);

  md_state_e            state_q, state_d;
  logic [MD_CNT_W-1:0]  cnt_q, cnt_d;
  md_req_t              req_q, req_d;
  logic [MD_DW-1:0]     hi_d, lo_d;
  logic [2*MD_DW-1:0]   calc_c;

  md_calc u_calc (
    .op    (req_q.op),
    .a     (req_q.a),
    .b     (req_q.b),
    .hi    (hi),
    .lo    (lo),
    .nxt_c (calc_c)
  );

  assign busy = (state_q == MD_BUSY);

  // State, counter, request latch and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      hi      <= hi_d;
      lo      <= lo_d;
    end
  end

  // Accept, count down, and commit the result on the edge where busy falls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    hi_d    = hi;
    lo_d    = lo;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (md_is_mul(md_op) || md_is_div(md_op)) begin
            state_d = MD_BUSY;
            cnt_d   = md_is_div(md_op) ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
            req_d   = '{op: md_op, a: a, b: b};
          end else if (md_op == OP_MTHI) begin
            hi_d = a;
          end else if (md_op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      MD_BUSY: begin
        if (cnt_q <= MD_CNT_W'(1)) begin
          state_d      = MD_IDLE;
          cnt_d        = '0;
          {hi_d, lo_d} = calc_c;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed scoreboard bench for md_unit (default MULT_CYCLES=5, DIV_CYCLES=10).
module tb_md_unit;
  import md_pkg::*;

  logic               clk;
  logic               reset;
  logic               start;
  logic [MD_OP_W-1:0] md_op;
  logic [31:0]        a;
  logic [31:0]        b;
  logic               busy;
  logic [31:0]        hi;
  logic [31:0]        lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] v;
    int          n;
  } exp_t;

  exp_t exp_q[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one op, scramble operands while busy, optionally poke a DIV start on busy cycle 'poke'.
  task automatic issue(input string tag, input logic [MD_OP_W-1:0] op,
                       input logic [31:0] ia, input logic [31:0] ib,
                       input logic [63:0] ev, input int en, input int poke);
    exp_t e;
    int   n;
    exp_q.push_back('{v: ev, n: en});
    @(negedge clk);
    start = 1'b1; md_op = op; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      start = (n == poke);
      md_op = start ? OP_DIV : op;
      a = $urandom; b = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    e = exp_q.pop_front();
    chk({tag, "_busy"}, 64'(n), 64'(e.n));
    chk({tag, "_hilo"}, {hi, lo}, e.v);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] ra, rb;
    logic [63:0] ev;
    longint      sa, sb;

    reset = 1'b1; start = 1'b0; md_op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    issue("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5, 0);
    issue("divu_7_2", OP_DIVU, 32'd7, 32'd2, {32'd1, 32'd3}, 10, 0);
    issue("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, 0);
    issue("mtlo", OP_MTLO, 32'h1234_5678, 32'd0, {32'hFFFF_FFFF, 32'h1234_5678}, 0, 0);
    issue("div_by0", OP_DIV, 32'd55, 32'd0, {32'hFFFF_FFFF, 32'h1234_5678}, 10, 0);
    issue("mthi", OP_MTHI, 32'hABCD_0000, 32'd0, {32'hABCD_0000, 32'h1234_5678}, 0, 0);
    issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 10, 0);
    issue("noop_f", 4'hF, 32'h5555_5555, 32'd1, {32'h0, 32'h8000_0000}, 0, 0);
    issue("multu_ign", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 2);

    // Random operands against a plain arithmetic reference.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom | 32'd1;
      case (i % 3)
        0: begin
          ev = {32'd0, ra} * {32'd0, rb};
          issue("rnd_multu", OP_MULTU, ra, rb, ev, 5, 0);
        end
        1: begin
          sa = $signed(ra);
          sb = $signed(rb);
          ev = 64'(sa * sb);
          issue("rnd_mult", OP_MULT, ra, rb, ev, 5, 0);
        end
        default: begin
          rb = rb >> (i % 17);
          if (rb == 0) rb = 32'd3;
          ev = {ra % rb, ra / rb};
          issue("rnd_divu", OP_DIVU, ra, rb, ev, 10, 0);
        end
      endcase
    end

`ifdef MD_UNIT_MADD_EN
    issue("madd_mtlo", OP_MTLO, 32'd10, 32'd0, {hi, 32'd10}, 0, 0);
    issue("madd_mthi", OP_MTHI, 32'd0, 32'd0, {32'd0, 32'd10}, 0, 0);
    issue("madd", OP_MADD, 32'd3, 32'd4, {32'd0, 32'd22}, 5, 0);
    issue("msubu", OP_MSUBU, 32'd1, 32'd23, 64'hFFFF_FFFF_FFFF_FFFF, 5, 0);
`else
    issue("nomadd_mtlo", OP_MTLO, 32'd10, 32'd0, {hi, 32'd10}, 0, 0);
    issue("nomadd_0110", OP_MADD, 32'd3, 32'd4, {hi, 32'd10}, 0, 0);
`endif

    // Reset in the middle of a divide: everything clears and no late update appears.
    exp_q.push_back('{v: 64'h0, n: 0});
    @(negedge clk);
    start = 1'b1; md_op = OP_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("rst_mid_busy", 64'(busy), 64'(e.n));
    chk("rst_mid_hilo", {hi, lo}, e.v);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_late_busy", 64'(busy), 64'd0);
    chk("rst_late_hilo", {hi, lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
